// File: rtl/mseq_pkg.sv
// Shared constants for the m-sequence generator: default polynomial/seed and packer byte width.
package mseq_pkg;
  localparam int          PACK_W   = 8;
  localparam logic [4:0]  DEF_TAPS = 5'b11101;
  localparam logic [4:0]  DEF_SEED = 5'b10101;
endpackage

// File: rtl/mseq_gen_if.sv
// Control and observation bundle of mseq_gen; master drives control, slave produces the sequence.
interface mseq_gen_if
  import mseq_pkg::*;
#(
  parameter int WIDTH = 5
);
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  load_phase;
  logic [WIDTH-1:0]  load_type;
  logic              out_fun;
  logic [WIDTH-1:0]  state;
  logic              frame_start;
  logic [WIDTH-1:0]  period_len;
  logic [PACK_W-1:0] data;
  logic              data_valid;
  logic              lockup;

  modport master (
    output en, load, load_phase, load_type,
    input  out_fun, state, frame_start, period_len, data, data_valid, lockup
  );

  modport slave (
    input  en, load, load_phase, load_type,
    output out_fun, state, frame_start, period_len, data, data_valid, lockup
  );
endinterface

// File: rtl/mseq_pack.sv
// Serial-to-byte packer: first shifted bit lands in the MSB; data/data_valid register one cycle
// after the byte-completing shift. clear restarts byte alignment without touching the last byte.
module mseq_pack
  import mseq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [PACK_W-1:0] data,
  output logic              data_valid
);
  localparam int CW = $clog2(PACK_W);

  logic [PACK_W-1:0] sreg_q, sreg_d, data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              vld_q, vld_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    vld_d  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (shift_en) begin
      sreg_d = {sreg_q[PACK_W-2:0], bit_in};
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CW'(PACK_W - 1)) begin
        data_d = sreg_d;
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data       = data_q;
  assign data_valid = vld_q;
endmodule

// File: rtl/mseq_gen.sv
// Loadable Fibonacci LFSR with period measurement, all-zero lockup recovery and byte packing.
// All outputs are registered; en=0 freezes the whole datapath.
module mseq_gen
  import mseq_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input logic       CLK_50MHZ,
  input logic       RST,
  mseq_gen_if.slave bus
);
  logic [WIDTH-1:0]  state_q, state_d, start_q, start_d, type_q, type_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d, period_q, period_d;
  logic              frame_q, frame_d, lockup_q, lockup_d;
  logic [WIDTH-1:0]  nxt, ld_phase;
  logic              fb, adv;
  logic [PACK_W-1:0] pk_data;
  logic              pk_vld;

  assign fb       = ^(state_q & type_q);
  assign nxt      = {state_q[WIDTH-2:0], fb};
  assign ld_phase = (bus.load_phase == '0) ? SEED : bus.load_phase;
  // Recovering from the all-zero state is not an advance: no shift into the packer.
  assign adv      = bus.en && !bus.load && (state_q != '0);

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    type_d   = type_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    lockup_d = lockup_q;
    frame_d  = 1'b0;
    if (bus.load) begin
      state_d  = ld_phase;
      start_d  = ld_phase;
      type_d   = bus.load_type;
      cnt_d    = '0;
      lockup_d = 1'b0;
    end else if (bus.en) begin
      if (state_q == '0) begin
        state_d  = start_q;
        lockup_d = 1'b1;
        cnt_d    = '0;
      end else begin
        state_d = nxt;
        if (nxt == start_q) begin
          frame_d  = 1'b1;
          period_d = cnt_q + 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q  <= SEED;
      start_q  <= SEED;
      type_q   <= TAPS;
      cnt_q    <= '0;
      period_q <= '0;
      frame_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      type_q   <= type_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      frame_q  <= frame_d;
      lockup_q <= lockup_d;
    end
  end

  mseq_pack u_pack (
    .clk        (CLK_50MHZ),
    .rst        (RST),
    .clear      (bus.load),
    .shift_en   (adv),
    .bit_in     (state_q[WIDTH-1]),
    .data       (pk_data),
    .data_valid (pk_vld)
  );

  assign bus.out_fun     = state_q[WIDTH-1];
  assign bus.state       = state_q;
  assign bus.frame_start = frame_q;
  assign bus.period_len  = period_q;
  assign bus.data        = pk_data;
  assign bus.data_valid  = pk_vld;
  assign bus.lockup      = lockup_q;
endmodule

// File: tb/tb_mseq_gen.sv
// Scoreboarded bench for mseq_gen: a behavioural model queues expected outputs per driven cycle.
module tb_mseq_gen;
  localparam int W = 5;

  logic CLK_50MHZ = 1'b0;
  logic RST;

  mseq_gen_if #(.WIDTH(W)) bus ();

  mseq_gen #(.WIDTH(W)) dut (
    .CLK_50MHZ (CLK_50MHZ),
    .RST       (RST),
    .bus       (bus)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  typedef struct packed {
    logic [W-1:0] state;
    logic         out_fun;
    logic         frame;
    logic [W-1:0] period;
    logic [7:0]   data;
    logic         dvld;
    logic         lock;
  } exp_t;

  exp_t sb_q[$];

  logic [W-1:0] m_state, m_start, m_type, m_cnt, m_period;
  logic [7:0]   m_data;
  logic         m_lock;
  bit           bits_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step(input logic rst, input logic ld, input logic e,
                      input logic [W-1:0] ph, input logic [W-1:0] ty);
    exp_t         x;
    logic         f, dv, fbit;
    logic [W-1:0] nx;
    RST = rst; bus.load = ld; bus.en = e; bus.load_phase = ph; bus.load_type = ty;
    f = 1'b0; dv = 1'b0;
    if (rst) begin
      m_state = 5'b10101; m_start = 5'b10101; m_type = 5'b11101;
      m_cnt = '0; m_period = '0; m_data = '0; m_lock = 1'b0;
      bits_q.delete();
    end else if (ld) begin
      m_state = (ph != '0) ? ph : 5'b10101;
      m_start = m_state; m_type = ty; m_cnt = '0; m_lock = 1'b0;
      bits_q.delete();
    end else if (e) begin
      if (m_state == '0) begin
        m_state = m_start; m_lock = 1'b1; m_cnt = '0;
      end else begin
        bits_q.push_back(m_state[W-1]);
        fbit = 1'b0;
        for (int i = 0; i < W; i++) if (m_type[i]) fbit ^= m_state[i];
        nx = (m_state << 1) | W'(fbit);
        if (nx == m_start) begin
          f = 1'b1; m_period = m_cnt + 1'b1; m_cnt = '0;
        end else begin
          m_cnt = m_cnt + 1'b1;
        end
        m_state = nx;
        if (bits_q.size() == 8) begin
          for (int i = 0; i < 8; i++) m_data[7-i] = bits_q[i];
          bits_q.delete();
          dv = 1'b1;
        end
      end
    end
    sb_q.push_back('{state: m_state, out_fun: m_state[W-1], frame: f, period: m_period,
                     data: m_data, dvld: dv, lock: m_lock});
    @(posedge CLK_50MHZ);
    #1;
    x = sb_q.pop_front();
    chk("state",       bus.state,       x.state);
    chk("out_fun",     bus.out_fun,     x.out_fun);
    chk("frame_start", bus.frame_start, x.frame);
    chk("period_len",  bus.period_len,  x.period);
    chk("data",        bus.data,        x.data);
    chk("data_valid",  bus.data_valid,  x.dvld);
    chk("lockup",      bus.lockup,      x.lock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int adv, f1, f2, nv, guard, vat;
    logic e;
    RST = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.load_phase = '0; bus.load_type = '0;
    @(negedge CLK_50MHZ);

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0, '0);
    chk("rst_state",  bus.state,      5'b10101);
    chk("rst_period", bus.period_len, 0);
    chk("rst_lockup", bus.lockup,     0);

    // Default polynomial, 62 advances: frames at steps 31 and 62
    adv = 0; f1 = 0; f2 = 0;
    repeat (62) begin
      step(1'b0, 1'b0, 1'b1, '0, '0);
      adv++;
      if (bus.frame_start === 1'b1) begin
        if (f1 == 0) f1 = adv; else if (f2 == 0) f2 = adv;
      end
    end
    chk("frame_at_31", f1, 31);
    chk("frame_at_62", f2, 62);
    chk("period_def",  bus.period_len, 31);

    // Loaded polynomial 10100 from phase 00001
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 5'b00001, 5'b10100);
    chk("load_state", bus.state, 5'b00001);
    repeat (31) step(1'b0, 1'b0, 1'b1, '0, '0);
    chk("period_ld", bus.period_len, 31);
    chk("frame_ld",  bus.frame_start, 1);

    // Zero feedback mask drains to all-zero, then lockup recovery
    step(1'b0, 1'b1, 1'b0, 5'b00001, 5'b00000);
    repeat (5) step(1'b0, 1'b0, 1'b1, '0, '0);
    chk("zero_state", bus.state, 5'b00000);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    chk("lock_set",     bus.lockup, 1);
    chk("lock_restart", bus.state,  5'b00001);
    step(1'b0, 1'b1, 1'b0, 5'b00000, 5'b11101);
    chk("lock_clear", bus.lockup, 0);
    chk("zero_phase_seed", bus.state, 5'b10101);

    // Random en over 64 advances: exactly 8 bytes
    adv = 0; nv = 0; guard = 0;
    while (adv < 64 && guard < 1000) begin
      e = 1'($urandom_range(0, 1));
      step(1'b0, 1'b0, e, '0, '0);
      if (e) adv++;
      if (bus.data_valid === 1'b1) nv++;
      guard++;
    end
    chk("rand_adv", adv, 64);
    chk("dvld_count", nv, 8);

    // load beats en; then reset in the middle of the third byte
    step(1'b0, 1'b1, 1'b1, 5'b00110, 5'b11101);
    chk("load_wins", bus.state, 5'b00110);
    repeat (19) step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b0, 1'b1, 5'b01010, 5'b00011);
    chk("rst2_state",  bus.state,       5'b10101);
    chk("rst2_data",   bus.data,        0);
    chk("rst2_dvld",   bus.data_valid,  0);
    chk("rst2_frame",  bus.frame_start, 0);
    chk("rst2_period", bus.period_len,  0);
    adv = 0; vat = 0;
    repeat (20) begin
      step(1'b0, 1'b0, 1'b1, '0, '0);
      adv++;
      if (bus.data_valid === 1'b1 && vat == 0) vat = adv;
    end
    chk("vld_after_rst", vat, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mseq_gen.md
MSEQ_GEN -- requirements
Module: mseq_gen

Interface
REQ-001 Parameter WIDTH, default 5: LFSR length in bits, legal range 3..16.
REQ-002 Parameter TAPS, default 5'b11101: reset-time feedback mask, WIDTH bits.
REQ-003 Parameter SEED, default 5'b10101: reset-time start phase, WIDTH bits, nonzero.
REQ-004 CLK_50MHZ  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  advance the sequence one step this cycle.
REQ-007 load  input  1  one-cycle strobe that loads phase and polynomial.
REQ-008 load_phase  input  WIDTH  new start phase, sampled when load=1.
REQ-009 load_type  input  WIDTH  new feedback mask, sampled when load=1.
REQ-010 out_fun  output  1  current sequence bit, equal to state[WIDTH-1].
REQ-011 state  output  WIDTH  current LFSR register.
REQ-012 frame_start  output  1  one-cycle pulse when the sequence returns to the start phase.
REQ-013 period_len  output  WIDTH  last measured period in steps.
REQ-014 data  output  8  last completed byte of out_fun, MSB-first.
REQ-015 data_valid  output  1  one-cycle pulse when data updates.
REQ-016 lockup  output  1  sticky flag set when an all-zero state is detected.

Function
REQ-017 Feedback: fb = XOR-reduce(state AND type_reg). Next state = {state[WIDTH-2:0], fb}.
REQ-018 When en=1 and load=0, state SHALL advance one step per cycle. When en=0, state, counters and packer SHALL hold.
REQ-019 load=1 SHALL take priority over en. On load: state<=load_phase, start_reg<=load_phase, type_reg<=load_type, step counter<=0, packer bit count<=0, lockup<=0. No advance occurs in that cycle.
REQ-020 A load with load_phase=0 SHALL load SEED instead.
REQ-021 The step counter is WIDTH bits and increments on each advance.
REQ-022 When an advance produces next state equal to start_reg, frame_start SHALL be 1 in the following cycle and period_len SHALL be set to counter+1. The counter SHALL reset to 0.
REQ-023 If the counter reaches all-ones without a return to start_reg (non-maximal polynomial), it SHALL wrap to 0. No frame_start is produced at the wrap.
REQ-024 If state==0 while en=1, state SHALL be set to start_reg instead of advancing, lockup SHALL be set to 1, and the counter SHALL be cleared.
REQ-025 Packer: on each advance, the current out_fun SHALL shift into an 8-bit shift register from the LSB side, so the first bit ends up as the MSB of the byte.
REQ-026 After the 8th shifted bit, data SHALL take the byte and data_valid SHALL pulse 1 in the next cycle.
REQ-027 frame_start and data_valid are registered; both MAY pulse in the same cycle.

Reset
REQ-028 On RST=1 at a clock edge, the following SHALL apply:
- state<=SEED, start_reg<=SEED, type_reg<=TAPS
- counter<=0, period_len<=0
- data<=0, data_valid<=0, frame_start<=0, lockup<=0, packer count<=0
REQ-029 RST SHALL override load and en. Reset mid-sequence SHALL discard any partial byte.

Structure
REQ-030 A shared package mseq_pkg SHALL hold the default TAPS/SEED constants and the packer byte width (8).
REQ-031 The serial-to-byte packer SHALL be a sub-module mseq_pack (clk, rst, shift_en, bit_in, data, data_valid).
REQ-032 Target implementation size is 120-400 lines of RTL.

Verification
REQ-033 Default parameters, RST then en=1 for 62 cycles:
- out_fun matches a golden model of polynomial 11101 from seed 10101.
- frame_start pulses at steps 31 and 62.
- period_len=31.
REQ-034 Load with phase 00001 and type 10100 (WIDTH=5), then en=1: state sequence matches the model, and period_len=31 after the first frame.
REQ-035 Force the all-zero state via load of type 00000 then en: lockup=1, state returns to start_reg, counter=0; a subsequent load clears lockup.
REQ-036 Toggle en at random over 64 advances: data_valid pulses exactly 8 times, each byte equals the 8 out_fun bits, MSB first.
REQ-037 Assert load and en in the same cycle, then RST during byte 3:
- The load wins with no advance.
- After RST, all outputs take their REQ-028 values and the next data_valid comes 8 advances later.
